// File: rtl/px_frame_writer.sv
// Frame sink: writes a raster-ordered pixel stream into a frame RAM,
// tracking column/line position and flagging line ends and frame completion.
module px_frame_writer #(
  parameter int PX_SIZE      = 8,
  parameter int IMAGE_WIDTH  = 400,
  parameter int IMAGE_HEIGHT = 400,
  parameter int ADDR_W       = 18,
  parameter int CNT_W        = 12
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [PX_SIZE-1:0] input_data,
  input  logic               input_data_valid,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [PX_SIZE-1:0] mem_data,
  output logic               mem_we,
  output logic               eol,
  output logic               frame_done,
  output logic               busy,
  output logic [CNT_W-1:0]   col,
  output logic [CNT_W-1:0]   line,
  output logic [15:0]        dropped_count
);

  typedef enum logic {IDLE, CAPTURE} state_t;

  localparam logic [CNT_W-1:0] COL_LAST  = CNT_W'(IMAGE_WIDTH - 1);
  localparam logic [CNT_W-1:0] LINE_LAST = CNT_W'(IMAGE_HEIGHT - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    col_q, col_d, line_q, line_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, mem_addr_q, mem_addr_d;
  logic [PX_SIZE-1:0]  mem_data_q, mem_data_d;
  logic                mem_we_q, mem_we_d, eol_q, eol_d, fd_q, fd_d;
  logic [15:0]         dropped_q, dropped_d;

  logic accept, last_col, last_px;

  assign accept   = (state_q == CAPTURE) && input_data_valid;
  assign last_col = (col_q == COL_LAST);
  assign last_px  = accept && last_col && (line_q == LINE_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (resetn) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; leaving CAPTURE on the last accepted pixel makes busy
  // drop in the same cycle that frame_done is presented.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)   state_d = CAPTURE;
      CAPTURE: if (last_px) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    col_d      = col_q;
    line_d     = line_q;
    addr_d     = addr_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_we_d   = 1'b0;
    eol_d      = 1'b0;
    fd_d       = 1'b0;
    dropped_d  = dropped_q;
    if (state_q == IDLE) begin
      if (start) begin
        col_d  = '0;
        line_d = '0;
        addr_d = '0;
      end
      if (input_data_valid && (dropped_q != '1))
        dropped_d = dropped_q + 16'd1;
    end else if (accept) begin
      mem_we_d   = 1'b1;
      mem_data_d = input_data;
      mem_addr_d = addr_q;
      if (last_col) begin
        col_d = '0;
        eol_d = 1'b1;
        if (line_q == LINE_LAST) begin
          line_d = '0;
          addr_d = '0;
          fd_d   = 1'b1;
        end else begin
          line_d = line_q + CNT_W'(1);
          addr_d = addr_q + ADDR_W'(1);
        end
      end else begin
        col_d  = col_q + CNT_W'(1);
        addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      col_q      <= '0;
      line_q     <= '0;
      addr_q     <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_we_q   <= 1'b0;
      eol_q      <= 1'b0;
      fd_q       <= 1'b0;
      dropped_q  <= '0;
    end else begin
      col_q      <= col_d;
      line_q     <= line_d;
      addr_q     <= addr_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_we_q   <= mem_we_d;
      eol_q      <= eol_d;
      fd_q       <= fd_d;
      dropped_q  <= dropped_d;
    end
  end

  // Output logic
  always_comb begin
    busy          = (state_q == CAPTURE);
    mem_addr      = mem_addr_q;
    mem_data      = mem_data_q;
    mem_we        = mem_we_q;
    eol           = eol_q;
    frame_done    = fd_q;
    col           = col_q;
    line          = line_q;
    dropped_count = dropped_q;
  end

endmodule

// File: tb/tb_px_frame_writer.sv
// Directed bench for px_frame_writer on a 4x3 frame.
module tb_px_frame_writer;

  localparam int PX = 8;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int AW = 18;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          resetn, start, input_data_valid;
  logic [PX-1:0] input_data;
  logic [AW-1:0] mem_addr;
  logic [PX-1:0] mem_data;
  logic          mem_we, eol, frame_done, busy;
  logic [CW-1:0] col, line;
  logic [15:0]   dropped_count;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_drop;

  px_frame_writer #(
    .PX_SIZE(PX), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .ADDR_W(AW), .CNT_W(CW)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .input_data(input_data), .input_data_valid(input_data_valid),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .eol(eol), .frame_done(frame_done), .busy(busy),
    .col(col), .line(line), .dropped_count(dropped_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks the write issued for the i-th pixel (1-based) of a frame.
  task automatic chk_write(input int i, input logic [7:0] d);
    chk("we",    32'(mem_we), 32'd1);
    chk("addr",  32'(mem_addr), 32'(i - 1));
    chk("data",  32'(mem_data), 32'(d));
    chk("eol",   32'(eol), 32'(i % W == 0));
    chk("fdone", 32'(frame_done), 32'(i == W * H));
    chk("busy",  32'(busy), 32'(i != W * H));
    chk("col",   32'(col), 32'(i % W));
    chk("line",  32'(line), 32'((i / W) % H));
  endtask

  initial begin
    resetn = 1'b1; start = 1'b0; input_data_valid = 1'b0; input_data = '0;
    tick(); tick();
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_data", 32'(mem_data), 32'd0);
    chk("rst_we",   32'(mem_we), 32'd0);
    chk("rst_eol",  32'(eol), 32'd0);
    chk("rst_fd",   32'(frame_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_col",  32'(col), 32'd0);
    chk("rst_line", 32'(line), 32'd0);
    chk("rst_drop", 32'(dropped_count), 32'd0);
    resetn = 1'b0;
    tick();

    // 1: back-to-back frame
    start = 1'b1; tick(); start = 1'b0;
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_we0",  32'(mem_we), 32'd0);
    for (int i = 1; i <= W * H; i++) begin
      input_data_valid = 1'b1; input_data = 8'(i);
      tick();
      chk_write(i, 8'(i));
    end
    input_data_valid = 1'b0;
    tick();
    chk("t1_we_end", 32'(mem_we), 32'd0);
    chk("t1_fd_end", 32'(frame_done), 32'd0);
    chk("t1_drop",   32'(dropped_count), 32'd0);

    // 2: valid toggling 1,0
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 1; i <= W * H; i++) begin
      input_data_valid = 1'b1; input_data = 8'(8'h20 + i);
      tick();
      chk_write(i, 8'(8'h20 + i));
      input_data_valid = 1'b0;
      tick();
      chk("t2_gap_we",   32'(mem_we), 32'd0);
      chk("t2_gap_col",  32'(col), 32'(i % W));
      chk("t2_gap_line", 32'(line), 32'((i / W) % H));
      chk("t2_gap_eol",  32'(eol), 32'd0);
    end

    // 3: drops before start, then start together with a valid pixel
    for (int i = 0; i < 5; i++) begin
      input_data_valid = 1'b1; input_data = 8'hA0;
      tick();
      chk("t3_idle_we", 32'(mem_we), 32'd0);
    end
    chk("t3_drop5", 32'(dropped_count), 32'd5);
    start = 1'b1; tick(); start = 1'b0;
    chk("t3_drop6", 32'(dropped_count), 32'd6);
    chk("t3_busy",  32'(busy), 32'd1);
    chk("t3_we0",   32'(mem_we), 32'd0);
    for (int i = 1; i <= 6; i++) begin
      input_data = 8'(8'h50 + i);
      tick();
      chk_write(i, 8'(8'h50 + i));
    end

    // 4: reset mid-frame after pixel 6
    resetn = 1'b1; tick();
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_col",  32'(col), 32'd0);
    chk("t4_line", 32'(line), 32'd0);
    chk("t4_drop", 32'(dropped_count), 32'd0);
    chk("t4_we",   32'(mem_we), 32'd0);
    resetn = 1'b0; tick();
    chk("t4_idle_we",   32'(mem_we), 32'd0);
    chk("t4_idle_drop", 32'(dropped_count), 32'd1);
    exp_drop = 1;
    input_data_valid = 1'b0;
    tick();

    // 5: restart ignored mid-frame; pixel right after frame_done dropped
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 1; i <= W * H; i++) begin
      input_data_valid = 1'b1; input_data = 8'(8'h80 + i);
      start = (i == 5 || i == 6);
      tick();
      chk_write(i, 8'(8'h80 + i));
    end
    start = 1'b0; input_data = 8'hEE;
    tick();
    exp_drop++;
    chk("t5_we_after",   32'(mem_we), 32'd0);
    chk("t5_drop_after", 32'(dropped_count), 32'(exp_drop));
    chk("t5_busy_after", 32'(busy), 32'd0);
    input_data_valid = 1'b0;
    tick();

    // 6: saturation of the drop counter
    force dut.dropped_q = 16'hFFFE;
    #1;
    release dut.dropped_q;
    #1;
    chk("t6_preset", 32'(dropped_count), 32'h0000FFFE);
    for (int i = 0; i < 3; i++) begin
      input_data_valid = 1'b1;
      tick();
      chk("t6_sat", 32'(dropped_count), 32'h0000FFFF);
    end
    input_data_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
